// File: rtl/apb_names_pkg.sv
// rtl/apb_names_pkg.sv - shared APB master FSM states and bus constants
//
// Purpose: FSM state encoding and strobe width shared by apb_cmd_master
//          and its helpers.
// Ports:   none (package)

package apb_names_pkg;

  localparam int APB_STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_tmo_cnt.sv
// rtl/apb_tmo_cnt.sv - ACCESS-phase timeout counter
//
// Purpose: 16-bit counter cleared on entry to ACCESS, advanced on each
//          stalled ACCESS cycle; flags when it sits at TMO-1.
// Ports:   pclk, preset_n - clock, async active-low reset
//          clear          - zero the counter (has priority over count)
//          count          - increment by one
//          expired        - counter value equals TMO-1

module apb_tmo_cnt #(
  parameter int TMO = 64
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  logic [15:0] cnt;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expired = (cnt == TMO_LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - command/response to APB4 master bridge
//
// Purpose: accepts one command at a time, runs a single APB4 transfer
//          (SETUP then ACCESS until pready) and returns a response.
// Ports:   pclk, preset_n            - clock, async active-low reset
//          cmd_valid/cmd_ready       - command handshake
//          cmd_addr/write/wdata/strb/prot - command fields
//          rsp_valid/rsp_ready       - response handshake
//          rsp_rdata/rsp_err/rsp_tmo - response fields
//          psel..pwdata, prdata/pready/pslverr - APB4 master port
// Config:  APB_CMD_MASTER_TIMEOUT_EN - abort ACCESS after TMO stalled cycles

module apb_cmd_master
  import apb_names_pkg::*;
#(
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter int TMO  = 64
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR-1:0]       cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA-1:0]       cmd_wdata,
  input  logic [APB_STRB_W-1:0] cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA-1:0]       rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_tmo,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR-1:0]       paddr,
  output logic [2:0]            pprot,
  output logic [APB_STRB_W-1:0] pstrb,
  output logic [DATA-1:0]       pwdata,
  input  logic [DATA-1:0]       prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_e            state;
  logic [ADDR-1:0]       a_addr;
  logic                  a_write;
  logic [DATA-1:0]       a_wdata;
  logic [APB_STRB_W-1:0] a_strb;
  logic [2:0]            a_prot;
  logic [DATA-1:0]       r_rdata;
  logic                  r_err;
  logic                  busy;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  logic tmo_expired;
  logic r_tmo;

  apb_tmo_cnt #(
    .TMO(TMO)
  ) u_tmo (
    .pclk    (pclk),
    .preset_n(preset_n),
    .clear   (state == SETUP),
    .count   (state == ACCESS && !pready),
    .expired (tmo_expired)
  );
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state   <= IDLE;
      a_addr  <= '0;
      a_write <= 1'b0;
      a_wdata <= '0;
      a_strb  <= '0;
      a_prot  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      r_tmo   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            a_addr  <= cmd_addr;
            a_write <= cmd_write;
            a_wdata <= cmd_wdata;
            // Reads never carry strobes, so zero them at capture time.
            a_strb  <= cmd_write ? cmd_strb : '0;
            a_prot  <= cmd_prot;
            state   <= SETUP;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          if (pready) begin
            r_rdata <= a_write ? '0 : prdata;
            r_err   <= pslverr;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            r_tmo   <= 1'b0;
`endif
            state   <= RESP;
          end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
          // A late pready in the expiring cycle wins over the timeout.
          else if (tmo_expired) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_tmo   <= 1'b1;
            state   <= RESP;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // APB fields come straight from the captured command while a transfer
  // is live and are held at zero otherwise.
  assign busy      = (state == SETUP) || (state == ACCESS);
  assign psel      = busy;
  assign penable   = (state == ACCESS);
  assign pwrite    = busy & a_write;
  assign paddr     = busy ? a_addr  : '0;
  assign pprot     = busy ? a_prot  : '0;
  assign pstrb     = busy ? a_strb  : '0;
  assign pwdata    = busy ? a_wdata : '0;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  assign rsp_tmo   = r_tmo;
`else
  assign rsp_tmo   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - directed self-checking bench for apb_cmd_master

module tb_apb_cmd_master;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  apb_cmd_master #(.ADDR(32), .DATA(32), .TMO(8)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pprot(pprot), .pstrb(pstrb), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One complete command. waits = stalled ACCESS cycles before pready
  // (large value = never); hold = cycles rsp_ready stays low in RESP.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot,
                      input int waits, input logic [31:0] rd, input logic serr,
                      input int hold, input logic [31:0] exp_rdata,
                      input logic exp_err, input logic exp_tmo, input int exp_pen);
    int pen;
    logic [3:0] exp_strb;
    exp_strb = wr ? strb : 4'h0;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("idle_psel", psel, 0);
    @(negedge pclk);
    // SETUP: command fields removed to prove they were registered; junk
    // on the slave inputs must be ignored here.
    cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    pready = 1'b1; prdata = 32'hBAD0_0001; pslverr = 1'b1;
    chk("setup_sel_en", {psel, penable}, 2'b10);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_pstrb", pstrb, exp_strb);
    chk("setup_pprot", pprot, prot);
    chk("setup_cmd_ready", cmd_ready, 0);
    if (wr) chk("setup_pwdata", pwdata, wdata);
    pen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk);
      if (!(psel && penable)) break;
      pen++;
      chk("access_paddr", paddr, addr);
      chk("access_pstrb", pstrb, exp_strb);
      if (pen == waits + 1) begin
        pready = 1'b1; prdata = rd; pslverr = serr;
      end else begin
        pready = 1'b0; prdata = 32'hFFFF_FFFF; pslverr = 1'b1;
      end
    end
    chk("penable_cycles", pen, exp_pen);
    // RESP: slave inputs again carry junk that must not leak through.
    pready = 1'b1; prdata = 32'hBAD0_0002; pslverr = 1'b1;
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, exp_rdata);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_apb_idle", {psel, penable, pwrite, pstrb}, 0);
      @(negedge pclk);
    end
    rsp_ready = 1'b1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_tmo", rsp_tmo, exp_tmo);
    chk("resp_cmd_ready", cmd_ready, 0);
    chk("resp_apb_zero", paddr | pwdata, 0);
    @(negedge pclk);
    rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    preset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    #3;
    chk("rst_apb", {psel, penable, pwrite, pstrb, pprot}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_tmo}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    @(negedge pclk);
    preset_n = 1'b1;
    #1 chk("rst_cmd_ready", cmd_ready, 1);

    // zero-wait write: psel N+1, penable N+2, rsp_valid N+3
    xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 32'h5555_5555, 1'b0,
         0, 32'h0, 1'b0, 1'b0, 1);
    // read with 3 wait states, strobes forced off
    xfer(1'b0, 32'h0000_0004, 32'h0, 4'hF, 3'd2, 3, 32'h1234_5678, 1'b0,
         0, 32'h1234_5678, 1'b0, 1'b0, 4);
    // slave error on a write, response held 2 cycles
    xfer(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3, 3'd1, 1, 32'h0, 1'b1,
         2, 32'h0, 1'b1, 1'b0, 2);
    // read with rsp_ready low for 5 cycles
    xfer(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'd5, 0, 32'hA5A5_5A5A, 1'b0,
         5, 32'hA5A5_5A5A, 1'b0, 1'b0, 1);
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    // pready never arrives: abort after 8 ACCESS cycles
    xfer(1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'd0, 1000, 32'h7777_7777, 1'b0,
         0, 32'h0, 1'b1, 1'b1, 8);
    // pready in the 8th ACCESS cycle: normal completion
    xfer(1'b0, 32'h0000_0204, 32'h0, 4'h0, 3'd0, 7, 32'h0BAD_CAFE, 1'b0,
         0, 32'h0BAD_CAFE, 1'b0, 1'b0, 8);
`else
    // no timeout: waits well past TMO and still completes normally
    xfer(1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'd0, 20, 32'h0BAD_CAFE, 1'b0,
         0, 32'h0BAD_CAFE, 1'b0, 1'b0, 21);
`endif

    // reset pulse mid-ACCESS
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0300;
    cmd_wdata = 32'h1111_2222; cmd_strb = 4'hF; cmd_prot = 3'd7;
    @(negedge pclk);
    cmd_valid = 1'b0; pready = 1'b0;
    @(negedge pclk);
    chk("pre_rst_access", {psel, penable}, 2'b11);
    #2 preset_n = 1'b0;
    #1;
    chk("arst_apb", {psel, penable, pwrite, pstrb, pprot}, 0);
    chk("arst_bus", paddr | pwdata, 0);
    chk("arst_rsp", {rsp_valid, rsp_err, rsp_tmo}, 0);
    @(negedge pclk);
    preset_n = 1'b1;
    #1 chk("arst_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("arst_no_rsp", {rsp_valid, psel}, 0);
    end

    // normal operation resumes after reset
    xfer(1'b1, 32'h0000_0040, 32'h0F0F_0F0F, 4'h5, 3'd3, 0, 32'h9999_9999, 1'b0,
         1, 32'h0, 1'b0, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
